// File: rtl/adc_uart_framer.sv
// ADC sample packetiser: buffers 14-bit samples in a FIFO and sends each one to the
// UART transmitter as a 4-byte frame (header, high, low, checksum) over start/busy.
module adc_uart_framer #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter bit          INVERT      = 1'b1,
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [13:0]                     sample_in,
    input  logic                            sample_valid,
    input  logic                            tx_busy,
    output logic [7:0]                      tx_data,
    output logic                            tx_start,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    output logic                            frame_active
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, ACK, WAIT} state_t;

    state_t          state, state_d;
    logic [13:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]      b1, b2;
    logic [1:0]      idx, idx_d;
    logic [TW-1:0]   timer, timer_d;
    logic [7:0]      tx_data_d;
    logic            tx_start_d;
    logic            pop_c, push_c, full_c;
    logic [13:0]     s_c, v_c;
    logic [7:0]      byte_c;

    // Head-of-FIFO conversion; the most negative sample saturates when negated
    always_comb begin
        s_c = mem[rd_ptr];
        if (INVERT) begin
            v_c = (s_c == 14'h2000) ? 14'h1FFF : 14'(~s_c + 14'd1);
        end else begin
            v_c = s_c;
        end
    end

    always_comb begin
        byte_c = HEADER;
        case (idx)
            2'd0: byte_c = HEADER;
            2'd1: byte_c = b1;
            2'd2: byte_c = b2;
            2'd3: byte_c = b1 ^ b2;
            default: byte_c = HEADER;
        endcase
    end

    assign full_c = (fifo_count == CW'(FIFO_DEPTH));
    assign push_c = sample_valid && (!full_c || pop_c);

    // Frame sequencer next-state and output logic
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        timer_d    = timer;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;
        pop_c      = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) state_d = LOAD;
            end
            LOAD: begin
                pop_c   = 1'b1;
                idx_d   = 2'd0;
                state_d = START;
            end
            START: begin
                if (!tx_busy) begin
                    tx_data_d  = byte_c;
                    tx_start_d = 1'b1;
                    timer_d    = '0;
                    state_d    = ACK;
                end
            end
            ACK: begin
                if (tx_busy || timer == TW'(ACK_TIMEOUT - 1)) begin
                    state_d = WAIT;
                end else begin
                    timer_d = TW'(timer + 1'b1);
                end
            end
            WAIT: begin
                if (!tx_busy) begin
                    if (idx != 2'd3) begin
                        idx_d   = 2'(idx + 2'd1);
                        state_d = START;
                    end else if (fifo_count != '0) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= '0;
            timer        <= '0;
            tx_data      <= 8'h00;
            tx_start     <= 1'b0;
            frame_active <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            overflow     <= 1'b0;
            b1           <= 8'h00;
            b2           <= 8'h00;
        end else begin
            state        <= state_d;
            idx          <= idx_d;
            timer        <= timer_d;
            tx_data      <= tx_data_d;
            tx_start     <= tx_start_d;
            frame_active <= (state_d != IDLE);
            if (push_c) wr_ptr <= AW'(wr_ptr + 1'b1);
            if (pop_c) begin
                rd_ptr <= AW'(rd_ptr + 1'b1);
                b1     <= {v_c[13], v_c[13], v_c[13:8]};
                b2     <= v_c[7:0];
            end
            case ({push_c, pop_c})
                2'b10:   fifo_count <= CW'(fifo_count + 1'b1);
                2'b01:   fifo_count <= CW'(fifo_count - 1'b1);
                default: fifo_count <= fifo_count;
            endcase
            if (sample_valid && !push_c) overflow <= 1'b1;
        end
    end

    // Sample storage needs no reset; pointers define what is valid
    always_ff @(posedge clk) begin
        if (rst && push_c) mem[wr_ptr] <= sample_in;
    end

endmodule

// File: tb/tb_adc_uart_framer.sv
// Bench for adc_uart_framer: two instances (pass-through and inverting) share stimulus;
// received bytes are scored against frames computed from sample values.
module tb_adc_uart_framer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned ACK_TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] sample_in;
    logic        sample_valid;
    logic [1:0]  busy;
    logic [1:0]  start;
    logic [1:0]  ovf;
    logic [1:0]  act;
    logic [7:0]  data [2];
    logic [3:0]  cnt [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_len = 10;
    int rem [2];
    int pcount [2];
    int last_cyc [2];
    int first_cyc [2];
    int push_cyc = 0;
    bit timeout_mode = 1'b0;
    logic [7:0] rx0 [$];
    logic [7:0] rx1 [$];
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    logic [13:0] smp [12];

    adc_uart_framer #(.FIFO_DEPTH(DEPTH), .INVERT(1'b0), .HEADER(8'hA5), .ACK_TIMEOUT(ACK_TO)) dut_p (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .tx_busy(busy[0]), .tx_data(data[0]), .tx_start(start[0]), .fifo_count(cnt[0]),
        .overflow(ovf[0]), .frame_active(act[0]));

    adc_uart_framer #(.FIFO_DEPTH(DEPTH), .INVERT(1'b1), .HEADER(8'hA5), .ACK_TIMEOUT(ACK_TO)) dut_n (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .tx_busy(busy[1]), .tx_data(data[1]), .tx_start(start[1]), .fifo_count(cnt[1]),
        .overflow(ovf[1]), .frame_active(act[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame bytes from the sample value using plain integer arithmetic
    function automatic logic [31:0] frame_bytes(input logic [13:0] s, input bit inv);
        int sv;
        int v;
        logic [7:0] hi;
        logic [7:0] lo;
        sv = int'($signed(s));
        if (inv) v = (sv == -8192) ? 8191 : -sv;
        else     v = sv;
        hi = 8'((v >>> 8) & 255);
        lo = 8'(v & 255);
        return {8'hA5, hi, lo, hi ^ lo};
    endfunction

    task automatic add_exp(input int k, input logic [31:0] f);
        for (int i = 3; i >= 0; i--) begin
            if (k == 0) exp0.push_back(f[i*8 +: 8]);
            else        exp1.push_back(f[i*8 +: 8]);
        end
    endtask

    // UART monitor and busy model, both away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (start[k] === 1'b1) begin
                check($sformatf("start_while_busy%0d", k), 32'(busy[k]), 32'd0);
                if (pcount[k] > 0) begin
                    check($sformatf("gap_min%0d", k), 32'(cyc - last_cyc[k] >= 3), 32'd1);
                    if (timeout_mode && (pcount[k] % 4) != 0)
                        check($sformatf("gap_timeout%0d", k), 32'(cyc - last_cyc[k]), 32'(ACK_TO + 2));
                end else begin
                    first_cyc[k] = cyc;
                end
                last_cyc[k] = cyc;
                pcount[k]++;
                if (k == 0) rx0.push_back(data[k]);
                else        rx1.push_back(data[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (start[k] === 1'b1 && busy_len > 0) begin
                busy[k] = 1'b1;
                rem[k]  = busy_len;
            end else if (rem[k] > 0) begin
                rem[k]--;
                if (rem[k] == 0) busy[k] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        rx0.delete(); rx1.delete(); exp0.delete(); exp1.delete();
        pcount[0] = 0; pcount[1] = 0;
    endtask

    task automatic do_reset(input int n, input bit pulse);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            sample_valid = pulse && (i % 2 == 0);
            sample_in    = 14'h1555;
            tick();
        end
        sample_valid = 1'b0;
        rst = 1'b1;
        clear_q();
    endtask

    task automatic push(input logic [13:0] s, input bit accept);
        sample_in    = s;
        sample_valid = 1'b1;
        tick();
        push_cyc     = cyc;
        sample_valid = 1'b0;
        if (accept) begin
            add_exp(0, frame_bytes(s, 1'b0));
            add_exp(1, frame_bytes(s, 1'b1));
        end
    endtask

    task automatic wait_drain(input string tag, input int nbytes, input int budget);
        int t;
        t = 0;
        while ((rx0.size() < nbytes || rx1.size() < nbytes) && t < budget) begin
            tick();
            t++;
        end
        if (t >= budget) check({tag, "_drain_timeout"}, 32'(rx0.size()), 32'(nbytes));
        repeat (20) tick();
    endtask

    task automatic compare_frames(input string tag);
        check({tag, "_len0"}, 32'(rx0.size()), 32'(exp0.size()));
        check({tag, "_len1"}, 32'(rx1.size()), 32'(exp1.size()));
        for (int i = 0; i < rx0.size() && i < exp0.size(); i++)
            check($sformatf("%s_p_byte%0d", tag, i), 32'(rx0[i]), 32'(exp0[i]));
        for (int i = 0; i < rx1.size() && i < exp1.size(); i++)
            check($sformatf("%s_n_byte%0d", tag, i), 32'(rx1[i]), 32'(exp1[i]));
        clear_q();
    endtask

    task automatic check_quiet(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_data%0d", tag, k),  32'(data[k]), 32'h00);
            check($sformatf("%s_start%0d", tag, k), 32'(start[k]), 32'd0);
            check($sformatf("%s_count%0d", tag, k), 32'(cnt[k]), 32'd0);
            check($sformatf("%s_ovf%0d", tag, k),   32'(ovf[k]), 32'd0);
            check($sformatf("%s_act%0d", tag, k),   32'(act[k]), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        rst = 1'b0;
        sample_valid = 1'b0;
        sample_in = '0;
        busy = 2'b00;
        rem[0] = 0; rem[1] = 0;
        pcount[0] = 0; pcount[1] = 0;
        last_cyc[0] = 0; last_cyc[1] = 0;
        first_cyc[0] = 0; first_cyc[1] = 0;

        // Reset with strobes pulsing, then idle
        do_reset(2, 1'b1);
        check_quiet("reset");
        repeat (20) tick();
        check("idle_no_tx0", 32'(rx0.size()), 32'd0);
        check("idle_no_tx1", 32'(rx1.size()), 32'd0);
        check("idle_count", 32'(cnt[0]), 32'd0);

        // Single sample, latency and byte order
        busy_len = 10;
        push(14'h0123, 1'b1);
        wait_drain("single", 4, 400);
        check("latency0", 32'(first_cyc[0] - push_cyc), 32'd3);
        check("latency1", 32'(first_cyc[1] - push_cyc), 32'd3);
        check("single_pulses", 32'(pcount[0]), 32'd4);
        check("single_count", 32'(cnt[0]), 32'd0);
        check("single_act", 32'(act[0]), 32'd0);
        compare_frames("single");

        // Saturation corner and small values against known frames
        push(14'h2000, 1'b0);
        push(14'h3FFF, 1'b0);
        push(14'h0005, 1'b0);
        add_exp(0, frame_bytes(14'h2000, 1'b0));
        add_exp(0, frame_bytes(14'h3FFF, 1'b0));
        add_exp(0, frame_bytes(14'h0005, 1'b0));
        add_exp(1, 32'hA51FFFE0);
        add_exp(1, 32'hA5000101);
        add_exp(1, 32'hA5FFFB04);
        wait_drain("sat", 12, 1000);
        compare_frames("sat");

        // Transmitter that never acknowledges
        busy_len = 0;
        timeout_mode = 1'b1;
        push(14'h1234, 1'b1);
        wait_drain("timeout", 4, 400);
        check("timeout_pulses", 32'(pcount[0]), 32'd4);
        timeout_mode = 1'b0;
        compare_frames("timeout");

        // Random bursts that fit the FIFO
        for (int r = 0; r < 4; r++) begin
            busy_len = int'($urandom_range(1, 12));
            n = int'($urandom_range(1, DEPTH));
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 4)) tick();
                push(14'($urandom), 1'b1);
            end
            wait_drain("rand", n * 4, 3000);
            check("rand_ovf0", 32'(ovf[0]), 32'd0);
            check("rand_ovf1", 32'(ovf[1]), 32'd0);
            compare_frames($sformatf("rand%0d", r));
        end

        // Overflow: 12 back-to-back against a slow transmitter
        do_reset(1, 1'b0);
        busy_len = 100;
        for (int i = 0; i < 12; i++) smp[i] = 14'($urandom);
        for (int i = 0; i < 12; i++) push(smp[i], i < 9);
        check("ovf_count0", 32'(cnt[0]), 32'd8);
        check("ovf_count1", 32'(cnt[1]), 32'd8);
        check("ovf_flag0", 32'(ovf[0]), 32'd1);
        check("ovf_flag1", 32'(ovf[1]), 32'd1);
        wait_drain("ovf", 36, 6000);
        compare_frames("ovf");

        // Push coinciding with a pop while full
        do_reset(1, 1'b0);
        busy_len = 100;
        for (int i = 0; i < 9; i++) push(14'($urandom), 1'b1);
        check("full_count", 32'(cnt[0]), 32'd8);
        t = 0;
        while (!(rx0.size() >= 4 && busy[0] == 1'b0) && t < 1000) begin
            tick();
            t++;
        end
        check("full_wait", 32'(t < 1000), 32'd1);
        push(14'($urandom), 1'b1);
        check("pushpop_count0", 32'(cnt[0]), 32'd8);
        check("pushpop_count1", 32'(cnt[1]), 32'd8);
        check("pushpop_ovf0", 32'(ovf[0]), 32'd0);
        check("pushpop_ovf1", 32'(ovf[1]), 32'd0);
        push(14'($urandom), 1'b0);
        check("drop_ovf0", 32'(ovf[0]), 32'd1);
        check("drop_count0", 32'(cnt[0]), 32'd8);
        wait_drain("pushpop", 40, 6000);
        compare_frames("pushpop");

        // Reset while waiting on the low byte
        do_reset(1, 1'b0);
        busy_len = 10;
        push(14'h0ABC, 1'b1);
        push(14'h0DEF, 1'b1);
        t = 0;
        while (!(rx0.size() >= 3 && busy[0] == 1'b1) && t < 500) begin
            tick();
            t++;
        end
        check("midreset_wait", 32'(t < 500), 32'd1);
        rst = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("midreset_start%0d", k), 32'(start[k]), 32'd0);
            check($sformatf("midreset_count%0d", k), 32'(cnt[k]), 32'd0);
            check($sformatf("midreset_act%0d", k), 32'(act[k]), 32'd0);
        end
        rst = 1'b1;
        clear_q();
        repeat (30) tick();
        check("midreset_silent", 32'(rx0.size() + rx1.size()), 32'd0);
        push(14'h1ABC, 1'b1);
        wait_drain("after_reset", 4, 400);
        compare_frames("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_uart_framer.md
# adc_uart_framer

Packetiser between the amplifier/ADC SPI capture stage and the UART transmitter. Accepts signed 14-bit ADC samples on a one-cycle valid strobe, buffers them in a small FIFO, optionally negates them with saturation, and serialises each sample as a 4-byte frame (header, high byte, low byte, checksum). Bytes go to the async UART transmitter through its start/busy handshake. Replaces the free-running counter-driven transmit enable, so no sample is sent twice or silently skipped.

## Interface
- `FIFO_DEPTH`, 8: sample FIFO depth, power of two, 2..64.
- `INVERT`, 1: 1 = transmit saturated negation of each sample; 0 = pass through.
- `HEADER`, 8'hA5: first byte of every frame.
- `ACK_TIMEOUT`, 4: cycles to wait for `tx_busy` rise after `tx_start` before treating the byte as sent.
- `clk` input 1: system clock, 50 MHz; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-low; one clock, reset is synchronous and active-low.
- `sample_in` input 14: signed two's-complement ADC sample.
- `sample_valid` input 1: one-cycle strobe qualifying `sample_in`.
- `tx_busy` input 1: UART transmitter busy.
- `tx_data` output 8: byte presented to the UART transmitter.
- `tx_start` output 1: one-cycle start pulse to the UART transmitter.
- `fifo_count` output log2(FIFO_DEPTH)+1: samples currently buffered.
- `overflow` output 1: sticky flag, set when a sample is dropped.
- `frame_active` output 1: high from LOAD through the final byte's WAIT.

## Operation
- FIFO: a write happens on `sample_valid` when not full. If full and no pop in the same cycle, the sample is dropped and `overflow` is set. `overflow` clears only on reset.
- Simultaneous push and pop when full: both happen, nothing is dropped, and `fifo_count` is unchanged. The same holds for push and pop at any fill level.
- Pointers wrap modulo FIFO_DEPTH.
- Conversion at pop:
  - INVERT=1: v = −s, except s = −8192 gives v = +8191.
  - INVERT=0: v = s.
- Frame bytes:
  - B0 = HEADER.
  - B1 = {v[13], v[13], v[13:8]}, sign-extended to 8 bits.
  - B2 = v[7:0].
  - B3 = B1 ^ B2.
- FSM states: IDLE, LOAD, START, ACK, WAIT.
  - IDLE: go to LOAD when `fifo_count` != 0.
  - LOAD: pop one sample, latch the four frame bytes, set byte index to 0, go to START.
  - START: when `tx_busy` = 0, drive `tx_data` = B[idx], pulse `tx_start` for exactly one cycle, go to ACK. Otherwise stay.
  - ACK: hold `tx_data`. Go to WAIT when `tx_busy` = 1, or after ACK_TIMEOUT cycles without it.
  - WAIT: hold `tx_data` until `tx_busy` = 0. Then:
    - idx < 3: increment idx, go to START.
    - idx = 3, FIFO non-empty: go to LOAD.
    - idx = 3, FIFO empty: go to IDLE.
- Frames are never interleaved or truncated except by reset.

## Timing
- Reset values: `tx_data` = 8'h00, `tx_start` = 0, `fifo_count` = 0, `overflow` = 0, `frame_active` = 0, FSM = IDLE, FIFO pointers = 0.
- Reset mid-frame: the frame is abandoned and the FIFO is emptied. `tx_start` is low the cycle after reset is sampled.
- Latency: a sample written into an empty FIFO with IDLE and `tx_busy` = 0 gives `tx_start` for B0 three clocks after the `sample_valid` edge (write, LOAD, START).
- `fifo_count` updates the clock after the push/pop edge.
- `tx_data` is stable from the `tx_start` cycle until WAIT exits.
- Minimum spacing between `tx_start` pulses is 3 cycles.
- `tx_start` is never asserted while `tx_busy` = 1.

## Test plan
- Reset then idle: hold `rst` = 0 for 2 cycles with `sample_valid` pulsing. After release, all outputs are at reset values and `tx_start` stays 0 while the FIFO is empty.
- Single sample 14'h0123, INVERT=0, busy model 10 cycles/byte: bytes A5, 01, 23, 22 in order, 4 `tx_start` pulses, `fifo_count` returns to 0.
- INVERT=1 with samples −8192, −1, +5: B1/B2 pairs are 1F/FF, 00/01, FF/FB. Checksums are E0, 01, 04.
- FIFO_DEPTH=8, busy model 100 cycles/byte, 12 samples back-to-back: `fifo_count` reaches 8, `overflow` is set, 9 frames are transmitted (1 in flight plus 8 buffered), and frame order is preserved.
- Push on the same cycle as a pop while full: `fifo_count` stays at 8 and `overflow` stays 0.
- Busy model that never raises `tx_busy`: each byte advances after ACK_TIMEOUT = 4 cycles; the frame completes with 4 pulses.
- Reset asserted in WAIT of B2: no further `tx_start`, `fifo_count` = 0, and the next sample after release starts with an A5 header.
